// File: rtl/ref_row_writer.sv
// ref_row_writer: streams search-area beats into 16 row banks, counting committed rows
// and holding back the first beat of a row until the reader has released a bank.
module ref_row_writer #(
    parameter int PIX_W     = 8,
    parameter int BEAT_PIX  = 8,
    parameter int ROW_BEATS = 8,
    parameter int NUM_BANKS = 16,
    localparam int DW       = BEAT_PIX * PIX_W,
    localparam int AW       = $clog2(ROW_BEATS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [6:0]    area_rows,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          rd_row_done,
    output logic          wr_en,
    output logic [3:0]    wrR_sel,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic [6:0]    row_count,
    output logic [4:0]    rows_avail,
    output logic          busy,
    output logic          area_done
);
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
    state_t state, state_nx;
    logic [6:0] area_q;
    logic [AW-1:0] beat_idx;
    logic start_ok, accept, last, area_end;
    assign start_ok = state == IDLE && start && rows_avail == 5'd0;
    assign area_end = row_count == area_q;
    assign accept   = in_valid && in_ready;
    assign last     = accept && beat_idx == AW'(ROW_BEATS - 1);
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else     state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_ok) state_nx = area_rows == 7'd0 ? DONE : WRITE;
            WRITE:   if (area_end) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end
    // once the final row is committed, stop taking beats until the area closes
    always_comb begin
        busy      = state != IDLE;
        area_done = state == DONE;
        in_ready  = state == WRITE && !area_end && (beat_idx != '0 || rows_avail < 5'(NUM_BANKS));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en      <= 1'b0;
            wrR_sel    <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            row_count  <= '0;
            rows_avail <= '0;
            beat_idx   <= '0;
            area_q     <= '0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                wrR_sel  <= row_count[3:0];
                wr_addr  <= beat_idx;
                wr_data  <= in_data;
                beat_idx <= beat_idx + 1'b1;
            end
            if (start_ok) begin
                area_q    <= area_rows;
                row_count <= '0;
                beat_idx  <= '0;
            end else if (last) begin
                row_count <= row_count + 7'd1;
            end
            if (last && !rd_row_done) rows_avail <= rows_avail + 5'd1;
            else if (rd_row_done && !last && rows_avail != 5'd0) rows_avail <= rows_avail - 5'd1;
        end
    end
endmodule
